// File: rtl/tile_buffer_ctrl_if.sv
// Handshake bundle between the load/DMA writer, the MAC/ALU reader and tile_buffer_ctrl.
// The master modport is the writer/reader side; the slave modport is the controller.
interface tile_buffer_ctrl_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int TILE_ELEMS  = 32,
  parameter int NUM_BUFS    = 4,
  parameter int DEPTH_TILES = 64
);
  localparam int TW = DATA_WIDTH * TILE_ELEMS;
  localparam int BW = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
  localparam int PW = $clog2(DEPTH_TILES + 1);

  logic                   wr_valid;
  logic                   wr_ready;
  logic [BW-1:0]          wr_buf;
  logic [TW-1:0]          wr_tile;
  logic                   wr_last;
  logic                   wr_done;
  logic                   rd_req;
  logic [BW-1:0]          rd_buf;
  logic                   rd_rewind;
  logic [TW-1:0]          rd_data;
  logic                   rd_valid;
  logic                   rd_last;
  logic                   rd_err;
  logic                   clr;
  logic [BW-1:0]          clr_buf;
  logic [NUM_BUFS*PW-1:0] buf_len;

  modport master (
    output wr_valid, wr_buf, wr_tile, wr_last, rd_req, rd_buf, rd_rewind, clr, clr_buf,
    input  wr_ready, wr_done, rd_data, rd_valid, rd_last, rd_err, buf_len
  );

  modport slave (
    input  wr_valid, wr_buf, wr_tile, wr_last, rd_req, rd_buf, rd_rewind, clr, clr_buf,
    output wr_ready, wr_done, rd_data, rd_valid, rd_last, rd_err, buf_len
  );
endinterface

// File: rtl/tile_buffer_ctrl.sv
// N logical tile buffers in one tile memory, each with its own write/read pointer and sealed length.
// Optional macro TILE_BUF_WRAP_EN: read pointer wraps to tile 0 after the last tile for vector reuse.
module tile_buffer_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int TILE_ELEMS  = 32,
  parameter int NUM_BUFS    = 4,
  parameter int DEPTH_TILES = 64,
  parameter int READ_LAT    = 1
) (
  input logic               clk,
  input logic               rst,
  tile_buffer_ctrl_if.slave bus
);
  localparam int TW    = DATA_WIDTH * TILE_ELEMS;
  localparam int BW    = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
  localparam int PW    = $clog2(DEPTH_TILES + 1);
  localparam int WORDS = NUM_BUFS * DEPTH_TILES;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [TW-1:0]       mem_r [WORDS];
  logic [PW-1:0]       wr_ptr_r [NUM_BUFS];
  logic [PW-1:0]       rd_ptr_r [NUM_BUFS];
  logic [PW-1:0]       len_r [NUM_BUFS];
  logic [NUM_BUFS-1:0] sealed_r;

  logic          wr_clr_hit_s;
  logic          wr_ready_s;
  logic          wr_acc_s;
  logic [PW-1:0] wr_idx_s;
  logic [AW-1:0] wr_addr_s;
  logic          rd_clr_hit_s;
  logic          rd_end_s;
  logic          rd_acc_s;
  logic          rd_last_s;
  logic [PW-1:0] rd_idx_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [AW-1:0] rd_addr_s;

  logic          wr_done_r;
  logic          s1_valid_r;
  logic          s1_last_r;
  logic          s1_err_r;
  logic [TW-1:0] s1_data_r;
  logic [NUM_BUFS*PW-1:0] buf_len_s;

  // Write-side acceptance and target address; a sealed buffer restarts at tile 0.
  always_comb begin
    wr_clr_hit_s = bus.clr && (bus.clr_buf == bus.wr_buf);
    wr_ready_s   = ((wr_ptr_r[bus.wr_buf] != PW'(DEPTH_TILES)) || sealed_r[bus.wr_buf])
                   && !wr_clr_hit_s;
    wr_acc_s     = bus.wr_valid && wr_ready_s;
    wr_idx_s     = sealed_r[bus.wr_buf] ? {PW{1'b0}} : wr_ptr_r[bus.wr_buf];
    wr_addr_s    = AW'(bus.wr_buf) * AW'(DEPTH_TILES) + AW'(wr_idx_s);
  end

  // Read-side acceptance, tile index and next read pointer.
  always_comb begin
    rd_clr_hit_s = bus.clr && (bus.clr_buf == bus.rd_buf);
    rd_idx_s     = bus.rd_rewind ? {PW{1'b0}} : rd_ptr_r[bus.rd_buf];
`ifdef TILE_BUF_WRAP_EN
    rd_end_s     = 1'b0;
`else
    rd_end_s     = !bus.rd_rewind && (rd_ptr_r[bus.rd_buf] == len_r[bus.rd_buf]);
`endif
    rd_acc_s     = bus.rd_req && sealed_r[bus.rd_buf] && !rd_clr_hit_s && !rd_end_s;
    rd_last_s    = (rd_idx_s == (len_r[bus.rd_buf] - PW'(1)));
`ifdef TILE_BUF_WRAP_EN
    rd_ptr_nxt_s = rd_last_s ? {PW{1'b0}} : (rd_idx_s + PW'(1));
`else
    rd_ptr_nxt_s = rd_idx_s + PW'(1);
`endif
    rd_addr_s    = AW'(bus.rd_buf) * AW'(DEPTH_TILES) + AW'(rd_idx_s);
  end

  // Tile memory write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_addr_s] <= bus.wr_tile;
    end
  end

  // Per-buffer pointer/length/seal state; a write to the same buffer overrides the read's
  // pointer update, and clr overrides both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BUFS; b++) begin
        wr_ptr_r[b] <= {PW{1'b0}};
        rd_ptr_r[b] <= {PW{1'b0}};
        len_r[b]    <= {PW{1'b0}};
      end
      sealed_r <= {NUM_BUFS{1'b0}};
    end else begin
      for (int b = 0; b < NUM_BUFS; b++) begin
        if (bus.clr && (bus.clr_buf == BW'(b))) begin
          wr_ptr_r[b] <= {PW{1'b0}};
          rd_ptr_r[b] <= {PW{1'b0}};
          len_r[b]    <= {PW{1'b0}};
          sealed_r[b] <= 1'b0;
        end else begin
          if (rd_acc_s && (bus.rd_buf == BW'(b))) begin
            rd_ptr_r[b] <= rd_ptr_nxt_s;
          end
          if (wr_acc_s && (bus.wr_buf == BW'(b))) begin
            if (bus.wr_last) begin
              len_r[b]    <= wr_idx_s + PW'(1);
              sealed_r[b] <= 1'b1;
              wr_ptr_r[b] <= {PW{1'b0}};
              rd_ptr_r[b] <= {PW{1'b0}};
            end else begin
              len_r[b]    <= {PW{1'b0}};
              sealed_r[b] <= 1'b0;
              wr_ptr_r[b] <= wr_idx_s + PW'(1);
            end
          end
        end
      end
    end
  end

  // First read stage: memory read (read-before-write) plus status; data holds on rejects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_done_r  <= 1'b0;
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_err_r   <= 1'b0;
      s1_data_r  <= {TW{1'b0}};
    end else begin
      wr_done_r  <= wr_acc_s && bus.wr_last;
      s1_valid_r <= bus.rd_req;
      s1_last_r  <= rd_acc_s && rd_last_s;
      s1_err_r   <= bus.rd_req && !rd_acc_s;
      s1_data_r  <= rd_acc_s ? mem_r[rd_addr_s] : s1_data_r;
    end
  end

  generate
    if (READ_LAT >= 2) begin : g_lat2
      logic          out_valid_r;
      logic          out_last_r;
      logic          out_err_r;
      logic [TW-1:0] out_data_r;

      // Second read stage; s1_data_r already holds the last accepted tile on rejects.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          out_err_r   <= 1'b0;
          out_data_r  <= {TW{1'b0}};
        end else begin
          out_valid_r <= s1_valid_r;
          out_last_r  <= s1_last_r;
          out_err_r   <= s1_err_r;
          out_data_r  <= s1_data_r;
        end
      end

      assign bus.rd_valid = out_valid_r;
      assign bus.rd_last  = out_last_r;
      assign bus.rd_err   = out_err_r;
      assign bus.rd_data  = out_data_r;
    end else begin : g_lat1
      assign bus.rd_valid = s1_valid_r;
      assign bus.rd_last  = s1_last_r;
      assign bus.rd_err   = s1_err_r;
      assign bus.rd_data  = s1_data_r;
    end
  endgenerate

  // Pack per-buffer lengths; len_r is zero whenever a buffer is unsealed.
  always_comb begin
    buf_len_s = {(NUM_BUFS*PW){1'b0}};
    for (int b = 0; b < NUM_BUFS; b++) begin
      buf_len_s[b*PW +: PW] = len_r[b];
    end
  end

  assign bus.wr_ready = wr_ready_s;
  assign bus.wr_done  = wr_done_r;
  assign bus.buf_len  = buf_len_s;
endmodule

// File: tb/tb_tile_buffer_ctrl.sv
// Directed self-checking bench for tile_buffer_ctrl, run with READ_LAT=2.
// Expected results depend on whether TILE_BUF_WRAP_EN is defined.
module tb_tile_buffer_ctrl;
  localparam int DW = 8;
  localparam int TE = 32;
  localparam int NB = 4;
  localparam int DT = 64;
  localparam int RL = 2;
  localparam int TW = DW * TE;
  localparam int BW = 2;
  localparam int PW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_buffer_ctrl_if #(.DATA_WIDTH(DW), .TILE_ELEMS(TE), .NUM_BUFS(NB), .DEPTH_TILES(DT)) bus ();

  tile_buffer_ctrl #(
    .DATA_WIDTH(DW), .TILE_ELEMS(TE), .NUM_BUFS(NB), .DEPTH_TILES(DT), .READ_LAT(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [TW-1:0] got_data [8];
  logic          got_valid [8];
  logic          got_last [8];
  logic          got_err [8];

  function automatic logic [TW-1:0] rep(input logic [7:0] v);
    return {TE{v}};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid = 1'b0; bus.wr_buf = '0; bus.wr_tile = '0; bus.wr_last = 1'b0;
    bus.rd_req = 1'b0; bus.rd_buf = '0; bus.rd_rewind = 1'b0;
    bus.clr = 1'b0; bus.clr_buf = '0;
  endtask

  task automatic write_tile(input logic [BW-1:0] b, input logic [7:0] v, input logic last);
    bus.wr_valid = 1'b1; bus.wr_buf = b; bus.wr_tile = rep(v); bus.wr_last = last;
    cyc();
    bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
  endtask

  // Issues n back-to-back reads and records each response READ_LAT cycles later.
  task automatic read_burst(input logic [BW-1:0] b, input int n, input logic [7:0] rew);
    for (int k = 0; k < n + RL - 1; k++) begin
      bus.rd_req    = (k < n);
      bus.rd_buf    = b;
      bus.rd_rewind = (k < n) ? rew[k] : 1'b0;
      cyc();
      if (k >= RL - 1) begin
        got_valid[k-RL+1] = bus.rd_valid;
        got_last[k-RL+1]  = bus.rd_last;
        got_err[k-RL+1]   = bus.rd_err;
        got_data[k-RL+1]  = bus.rd_data;
      end
    end
    bus.rd_req = 1'b0; bus.rd_rewind = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err: got %b want 0", bus.rd_err); end
    checks++; if (bus.rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %b want 0", bus.rd_last); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done: got %b want 0", bus.wr_done); end
    checks++; if (bus.buf_len !== '0) begin errors++; $display("FAIL reset_buf_len: got %h want 0", bus.buf_len); end
    for (int b = 0; b < NB; b++) begin
      bus.wr_buf = BW'(b);
      #1;
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready[%0d]: got %b want 1", b, bus.wr_ready); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] ev [3];
    ev = '{8'h11, 8'h22, 8'h33};
    write_tile(2'd1, 8'h11, 1'b0);
    checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("FAIL basic_wr_done_early: got %b want 0", bus.wr_done); end
    write_tile(2'd1, 8'h22, 1'b0);
    write_tile(2'd1, 8'h33, 1'b1);
    checks++; if (bus.wr_done !== 1'b1) begin errors++; $display("FAIL basic_wr_done: got %b want 1", bus.wr_done); end
    cyc();
    checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("FAIL basic_wr_done_pulse: got %b want 0", bus.wr_done); end
    checks++; if (bus.buf_len[PW +: PW] !== 7'd3) begin errors++; $display("FAIL basic_buf_len1: got %0d want 3", bus.buf_len[PW +: PW]); end
    read_burst(2'd1, 3, 8'h00);
    for (int j = 0; j < 3; j++) begin
      checks++; if (got_valid[j] !== 1'b1 || got_err[j] !== 1'b0) begin errors++; $display("FAIL basic_rd_status[%0d]: got valid=%b err=%b want 1/0", j, got_valid[j], got_err[j]); end
      checks++; if (got_last[j] !== (j == 2)) begin errors++; $display("FAIL basic_rd_last[%0d]: got %b want %b", j, got_last[j], (j == 2)); end
      checks++; if (got_data[j] !== rep(ev[j])) begin errors++; $display("FAIL basic_rd_data[%0d]: got %h want %h", j, got_data[j], rep(ev[j])); end
    end
    cyc();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rd_idle: got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_full_and_clr();
    for (int i = 0; i < DT; i++) begin
      if (i == DT - 1) begin
        bus.wr_buf = 2'd0;
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_last_slot: got %b want 1", bus.wr_ready); end
      end
      write_tile(2'd0, 8'(i), 1'b0);
    end
    bus.wr_buf = 2'd0;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b want 0", bus.wr_ready); end
    write_tile(2'd0, 8'hEE, 1'b1);
    checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("FAIL full_ignored_done: got %b want 0", bus.wr_done); end
    cyc();
    checks++; if (bus.buf_len[0 +: PW] !== 7'd0) begin errors++; $display("FAIL full_ignored_len: got %0d want 0", bus.buf_len[0 +: PW]); end
    bus.clr = 1'b1; bus.clr_buf = 2'd0;
    bus.wr_valid = 1'b1; bus.wr_buf = 2'd0; bus.wr_tile = rep(8'hEE); bus.wr_last = 1'b1;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL clr_wr_ready: got %b want 0", bus.wr_ready); end
    cyc();
    bus.clr = 1'b0; bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
    #1;
    checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("FAIL clr_write_dropped: got %b want 0", bus.wr_done); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL clr_wr_ready_after: got %b want 1", bus.wr_ready); end
    write_tile(2'd0, 8'h5A, 1'b1);
    checks++; if (bus.wr_done !== 1'b1) begin errors++; $display("FAIL retry_wr_done: got %b want 1", bus.wr_done); end
    cyc();
    checks++; if (bus.buf_len[0 +: PW] !== 7'd1) begin errors++; $display("FAIL retry_buf_len0: got %0d want 1", bus.buf_len[0 +: PW]); end
    read_burst(2'd0, 1, 8'h00);
    checks++; if (got_data[0] !== rep(8'h5A)) begin errors++; $display("FAIL retry_rd_data: got %h want %h", got_data[0], rep(8'h5A)); end
    checks++; if (got_last[0] !== 1'b1 || got_err[0] !== 1'b0) begin errors++; $display("FAIL retry_rd_status: got last=%b err=%b want 1/0", got_last[0], got_err[0]); end
  endtask

  task automatic test_unsealed_read();
    read_burst(2'd2, 1, 8'h00);
    checks++; if (got_valid[0] !== 1'b1 || got_err[0] !== 1'b1) begin errors++; $display("FAIL unsealed_status: got valid=%b err=%b want 1/1", got_valid[0], got_err[0]); end
    checks++; if (got_last[0] !== 1'b0) begin errors++; $display("FAIL unsealed_last: got %b want 0", got_last[0]); end
    checks++; if (got_data[0] !== rep(8'h5A)) begin errors++; $display("FAIL unsealed_data_held: got %h want %h", got_data[0], rep(8'h5A)); end
  endtask

  task automatic test_same_cycle_rw();
    write_tile(2'd3, 8'hA0, 1'b0);
    write_tile(2'd3, 8'hA1, 1'b1);
    cyc();
    checks++; if (bus.buf_len[3*PW +: PW] !== 7'd2) begin errors++; $display("FAIL same_len_before: got %0d want 2", bus.buf_len[3*PW +: PW]); end
    bus.rd_req = 1'b1; bus.rd_buf = 2'd3; bus.rd_rewind = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_buf = 2'd3; bus.wr_tile = rep(8'hB0); bus.wr_last = 1'b0;
    cyc();
    bus.rd_req = 1'b0; bus.wr_valid = 1'b0;
    cyc();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b0 || bus.rd_last !== 1'b0) begin errors++; $display("FAIL same_rd_status: got v=%b e=%b l=%b want 1/0/0", bus.rd_valid, bus.rd_err, bus.rd_last); end
    checks++; if (bus.rd_data !== rep(8'hA0)) begin errors++; $display("FAIL same_rd_old_data: got %h want %h", bus.rd_data, rep(8'hA0)); end
    checks++; if (bus.buf_len[3*PW +: PW] !== 7'd0) begin errors++; $display("FAIL same_len_after: got %0d want 0", bus.buf_len[3*PW +: PW]); end
    read_burst(2'd3, 1, 8'h00);
    checks++; if (got_err[0] !== 1'b1) begin errors++; $display("FAIL same_filling_read: got err=%b want 1", got_err[0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ed [4];
    logic       el [4];
    logic       ee [4];
`ifdef TILE_BUF_WRAP_EN
    ed = '{8'hC0, 8'hC1, 8'hC0, 8'hC1};
    el = '{1'b0, 1'b1, 1'b0, 1'b1};
    ee = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    ed = '{8'hC0, 8'hC1, 8'hC1, 8'hC1};
    el = '{1'b0, 1'b1, 1'b0, 1'b0};
    ee = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
    write_tile(2'd1, 8'hC0, 1'b0);
    write_tile(2'd1, 8'hC1, 1'b1);
    cyc();
    checks++; if (bus.buf_len[PW +: PW] !== 7'd2) begin errors++; $display("FAIL b2b_buf_len1: got %0d want 2", bus.buf_len[PW +: PW]); end
    read_burst(2'd1, 4, 8'h00);
    for (int j = 0; j < 4; j++) begin
      checks++; if (got_valid[j] !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", j, got_valid[j]); end
      checks++; if (got_err[j] !== ee[j] || got_last[j] !== el[j]) begin errors++; $display("FAIL b2b_status[%0d]: got err=%b last=%b want %b/%b", j, got_err[j], got_last[j], ee[j], el[j]); end
      checks++; if (got_data[j] !== rep(ed[j])) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", j, got_data[j], rep(ed[j])); end
    end
    read_burst(2'd1, 1, 8'h01);
    checks++; if (got_err[0] !== 1'b0 || got_data[0] !== rep(8'hC0)) begin errors++; $display("FAIL b2b_rewind: got err=%b data=%h want 0/%h", got_err[0], got_data[0], rep(8'hC0)); end
  endtask

  task automatic test_reset_inflight();
    bus.rd_req = 1'b1; bus.rd_buf = 2'd1; bus.rd_rewind = 1'b1;
    cyc();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", bus.rd_valid); end
    bus.rd_req = 1'b0; bus.rd_rewind = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_no_valid[%0d]: got %b want 0", i, bus.rd_valid); end
    end
    checks++; if (bus.buf_len !== '0) begin errors++; $display("FAIL rst_buf_len: got %h want 0", bus.buf_len); end
    for (int b = 0; b < NB; b++) begin
      bus.wr_buf = BW'(b);
      #1;
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready[%0d]: got %b want 1", b, bus.wr_ready); end
    end
    read_burst(2'd1, 1, 8'h01);
    checks++; if (got_err[0] !== 1'b1) begin errors++; $display("FAIL rst_unsealed_read: got err=%b want 1", got_err[0]); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_full_and_clr();
    test_unsealed_read();
    test_same_cycle_rw();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
